glb_bus_issuer: RTL and testbench

//  Streams one ifmap/filter word sequence from a global-buffer read FIFO onto the
//  X-bus feed (GLB -> BUS direction) and tags each word with Y_ID/X_ID so the bus

---
 rtl/glb_bus_issuer.sv | 148 ++++++++++++++
 tb/tb_glb_bus_issuer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/glb_bus_issuer.sv
// glb_bus_issuer: streams GLB read-FIFO words onto the X-bus tagged with Y_ID/X_ID
module glb_bus_issuer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL = 8,
  parameter int NUM_ROW = 8,
  localparam int XW = $clog2(NUM_COL) + 1,
  localparam int YW = $clog2(NUM_ROW) + 1,
  localparam int RW = $clog2(255 * NUM_COL * NUM_ROW + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [XW-1:0]         cfg_x_len_i,
  input  logic [YW-1:0]         cfg_y_len_i,
  input  logic [7:0]            cfg_wpt_i,
  input  logic                  src_empty_i,
  output logic                  src_rd_en_o,
  input  logic [DATA_WIDTH-1:0] src_data_i,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  output logic [XW-1:0]         bus_x_id_o,
  output logic [YW-1:0]         bus_y_id_o,
  output logic                  bus_valid_o,
  input  logic                  bus_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [XW-1:0] x_len_q, x_len_d, x_q, x_d, infl_x_q, hx_q, hx_d, tx_q, tx_d, xl_c;
  logic [YW-1:0] y_len_q, y_len_d, y_q, y_d, infl_y_q, hy_q, hy_d, ty_q, ty_d, yl_c;
  logic [7:0] wpt_q, wpt_d, w_q, w_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] hd_q, hd_d, td_q, td_d;
  logic [1:0] cnt_q, cnt_d, occ;
  logic infl_q, rd, pop, push, w_last, x_last;
  assign xl_c = cfg_x_len_i > XW'(NUM_COL) ? XW'(NUM_COL) : cfg_x_len_i;
  assign yl_c = cfg_y_len_i > YW'(NUM_ROW) ? YW'(NUM_ROW) : cfg_y_len_i;
  assign bus_valid_o = cnt_q != 2'd0;
  assign bus_data_o = bus_valid_o ? hd_q : '0;
  assign bus_x_id_o = bus_valid_o ? hx_q : '0;
  assign bus_y_id_o = bus_valid_o ? hy_q : '0;
  assign busy_o = state_q == RUN;
  assign done_o = state_q == DONE;
  assign src_rd_en_o = rd;
  always_comb begin
    state_d = state_q;
    x_len_d = x_len_q;
    y_len_d = y_len_q;
    wpt_d = wpt_q;
    w_d = w_q;
    x_d = x_q;
    y_d = y_q;
    rem_d = rem_q;
    hd_d = hd_q;
    hx_d = hx_q;
    hy_d = hy_q;
    td_d = td_q;
    tx_d = tx_q;
    ty_d = ty_q;
    pop = bus_valid_o && bus_ready_i;
    push = infl_q;
    // a word popped this cycle frees its slot, keeping one word per cycle flowing
    occ = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    rd = (state_q == RUN) && !rst && !src_empty_i && (rem_q != '0) && (occ < 2'd2);
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    w_last = w_q == wpt_q - 8'd1;
    x_last = x_q == x_len_q - XW'(1);
    if (pop) begin
      if (cnt_q == 2'd2) begin
        hd_d = td_q;
        hx_d = tx_q;
        hy_d = ty_q;
      end else if (push) begin
        hd_d = src_data_i;
        hx_d = infl_x_q;
        hy_d = infl_y_q;
      end
    end else if (cnt_q == 2'd0 && push) begin
      hd_d = src_data_i;
      hx_d = infl_x_q;
      hy_d = infl_y_q;
    end
    if (push && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop))) begin
      td_d = src_data_i;
      tx_d = infl_x_q;
      ty_d = infl_y_q;
    end
    if (state_q == IDLE && start_i) begin
      x_len_d = xl_c;
      y_len_d = yl_c;
      wpt_d = cfg_wpt_i;
      w_d = '0;
      x_d = '0;
      y_d = '0;
      rem_d = RW'(cfg_wpt_i) * RW'(xl_c) * RW'(yl_c);
      state_d = (cfg_wpt_i == '0 || cfg_x_len_i == '0 || cfg_y_len_i == '0) ? DONE : RUN;
    end
    if (rd) begin
      w_d = w_last ? 8'd0 : w_q + 8'd1;
      x_d = w_last ? (x_last ? '0 : x_q + XW'(1)) : x_q;
      y_d = (w_last && x_last) ? y_q + YW'(1) : y_q;
      rem_d = rem_q - RW'(1);
    end
    if (state_q == RUN && rem_q == '0 && !infl_q && pop && cnt_q == 2'd1) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_len_q <= '0;
      y_len_q <= '0;
      wpt_q <= '0;
      w_q <= '0;
      x_q <= '0;
      y_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      infl_q <= 1'b0;
      infl_x_q <= '0;
      infl_y_q <= '0;
      hd_q <= '0;
      hx_q <= '0;
      hy_q <= '0;
      td_q <= '0;
      tx_q <= '0;
      ty_q <= '0;
    end else begin
      state_q <= state_d;
      x_len_q <= x_len_d;
      y_len_q <= y_len_d;
      wpt_q <= wpt_d;
      w_q <= w_d;
      x_q <= x_d;
      y_q <= y_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      infl_q <= rd;
      infl_x_q <= x_q;
      infl_y_q <= y_q;
      hd_q <= hd_d;
      hx_q <= hx_d;
      hy_q <= hy_d;
      td_q <= td_d;
      tx_q <= tx_d;
      ty_q <= ty_d;
    end
  end
endmodule

// File: tb/tb_glb_bus_issuer.sv
// tb_glb_bus_issuer: table-driven directed checks of glb_bus_issuer with a FIFO model
module tb_glb_bus_issuer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] cfg_x = '0, cfg_y = '0;
  logic [7:0] cfg_w = '0;
  logic src_empty, src_rd_en, bus_valid, busy, done;
  logic bus_ready = 1'b1;
  logic [15:0] src_data = '0, bus_data;
  logic [3:0] bus_x, bus_y;
  glb_bus_issuer dut (
    .clk(clk), .rst(rst), .start_i(start), .cfg_x_len_i(cfg_x), .cfg_y_len_i(cfg_y),
    .cfg_wpt_i(cfg_w), .src_empty_i(src_empty), .src_rd_en_o(src_rd_en), .src_data_i(src_data),
    .bus_data_o(bus_data), .bus_x_id_o(bus_x), .bus_y_id_o(bus_y), .bus_valid_o(bus_valid),
    .bus_ready_i(bus_ready), .busy_o(busy), .done_o(done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [15:0] mem [0:2047];
  int ptr = 0, avail = 4096;
  logic fifo_clr = 1'b0;
  assign src_empty = ptr >= avail;
  always @(posedge clk) begin
    if (fifo_clr) ptr <= 0;
    else if (src_rd_en) begin
      src_data <= mem[ptr];
      ptr <= ptr + 1;
    end
  end
  int rdy_mode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    bus_ready = (rdy_mode != 0) ? !bus_ready : 1'b1;
  end
  int rd_n, hs_n, done_n, first_rd, first_val, first_hs, last_hs, done_cyc, gap;
  int e_stab, e_out, e_zero, e_busy, e_empty;
  logic pv = 1'b0, pr = 1'b0;
  logic [15:0] pd;
  logic [3:0] px, py;
  logic [15:0] hd [0:2047];
  int hx [0:2047];
  int hy [0:2047];
  always @(negedge clk) begin
    if (src_rd_en) begin
      rd_n++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (src_rd_en && src_empty) e_empty++;
    if (bus_valid && first_val < 0) first_val = cyc;
    if (busy && first_val >= 0 && !bus_valid) gap = 1;
    if (bus_valid && bus_ready && hs_n < 2048) begin
      hd[hs_n] = bus_data;
      hx[hs_n] = int'(bus_x);
      hy[hs_n] = int'(bus_y);
      hs_n++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
    end
    if (rd_n - hs_n > 2) e_out++;
    if (pv && !pr && (!bus_valid || bus_data != pd || bus_x != px || bus_y != py)) e_stab++;
    if (!bus_valid && (bus_data != '0 || bus_x != '0 || bus_y != '0)) e_zero++;
    if (done) begin
      done_n++;
      done_cyc = cyc;
      if (busy) e_busy++;
    end
    pv = bus_valid;
    pr = bus_ready;
    pd = bus_data;
    px = bus_x;
    py = bus_y;
  end
  int total = 0, bad = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic mon_clear();
    rd_n = 0; hs_n = 0; done_n = 0; first_rd = -1; first_val = -1; first_hs = -1;
    last_hs = -1; done_cyc = -1; gap = 0;
    e_stab = 0; e_out = 0; e_zero = 0; e_busy = 0; e_empty = 0;
  endtask
  typedef struct {
    int wpt, xl, yl, mode, stall, restart, words, mx, b2b, gap;
  } vec_t;
  vec_t tv [8];
  int start_cyc, stall_t;
  task automatic run_seq(input vec_t v);
    rdy_mode = v.mode;
    @(posedge clk);
    #1;
    fifo_clr = 1'b1;
    @(posedge clk);
    #1;
    fifo_clr = 1'b0;
    avail = v.stall > 0 ? v.stall : 4096;
    stall_t = 0;
    mon_clear();
    cfg_w = 8'(v.wpt);
    cfg_x = 4'(v.xl);
    cfg_y = 4'(v.yl);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 3000 && done_n == 0; k++) begin
      if (v.restart != 0 && k == 3) begin
        start = 1'b1;
        cfg_w = 8'd0;
      end else start = 1'b0;
      if (v.stall > 0 && ptr >= avail && avail < 4096) begin
        stall_t++;
        if (stall_t >= 5) avail = 4096;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_n, 1);
    chk("words", hs_n, v.words);
    chk("reads", rd_n, v.words);
    for (int i = 0; i < hs_n && i < v.words; i++) begin
      chk($sformatf("data[%0d]", i), int'(hd[i]), int'(mem[i]));
      chk($sformatf("x_id[%0d]", i), hx[i], (i / v.wpt) % v.mx);
      chk($sformatf("y_id[%0d]", i), hy[i], i / (v.wpt * v.mx));
    end
    if (v.words == 0) begin
      chk("done_lat", done_cyc - start_cyc, 1);
      chk("no_valid", first_val, -1);
    end else begin
      chk("rd_to_valid", first_val - first_rd, 2);
      chk("done_after_last", done_cyc - last_hs, 1);
    end
    if (v.b2b != 0) chk("back_to_back", last_hs - first_hs, v.words - 1);
    if (v.gap != 2) chk("valid_gap", gap, v.gap);
    chk("stable_stall", e_stab, 0);
    chk("outstanding", e_out, 0);
    chk("idle_zero", e_zero, 0);
    chk("busy_in_done", e_busy, 0);
    chk("rd_when_empty", e_empty, 0);
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'(16'hA000 + i * 7);
    tv[0] = '{3, 2, 2, 0, 0, 0, 12, 2, 1, 0};
    tv[1] = '{3, 2, 2, 1, 0, 0, 12, 2, 0, 2};
    tv[2] = '{3, 2, 2, 0, 5, 0, 12, 2, 0, 1};
    tv[3] = '{0, 2, 2, 0, 0, 0, 0, 2, 0, 0};
    tv[4] = '{1, 11, 2, 0, 0, 1, 16, 8, 1, 0};
    tv[5] = '{2, 0, 3, 0, 0, 0, 0, 1, 0, 0};
    tv[6] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    tv[7] = '{2, 8, 8, 0, 0, 0, 128, 8, 1, 0};
    mon_clear();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(bus_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(src_rd_en), 0);
    chk("rst_data", int'(bus_data), 0);
    chk("rst_x", int'(bus_x), 0);
    chk("rst_y", int'(bus_y), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 8; t++) run_seq(tv[t]);
    rdy_mode = 0;
    @(posedge clk);
    #1;
    fifo_clr = 1'b1;
    @(posedge clk);
    #1;
    fifo_clr = 1'b0;
    avail = 4096;
    mon_clear();
    cfg_w = 8'd3;
    cfg_x = 4'd2;
    cfg_y = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 200 && hs_n < 5; k++) begin
      @(posedge clk);
      #1;
    end
    chk("abort_reached", int'(hs_n >= 5), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_rd_en", int'(src_rd_en), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", int'(bus_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_rd_en", int'(src_rd_en), 0);
    chk("abort_data", int'(bus_data), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", done_n, 0);
    run_seq(tv[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
